mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Iterative multiply/divide unit in the EX stage, beside the main ALU.
//  Takes operand A and the muxed operand B (ALU_B: register or sign-extended immediate).
//  Executes MULT/MULTU/DIV/DIVU over several cycles and holds the result in HI/LO.
//  The hazard unit stalls the pipeline while busy=1.
// PARAMETERS
//  DATA_W   32   operand width; HI and LO are each DATA_W bits
//  CNT_W    6    iteration counter width; must satisfy 2**CNT_W > DATA_W
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous, active-high reset
//  start        in   1        launch the op on op[1:0]; sampled only when idle
//  op           in   2        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  ALU_A        in   DATA_W   rs operand (multiplicand / dividend)
//  ALU_B        in   DATA_W   operand from the ALU source mux (multiplier / divisor)
//  hi_we        in   1        MTHI: HI <= wdata; honoured only when idle
//  lo_we        in   1        MTLO: LO <= wdata; honoured only when idle
//  wdata        in   DATA_W   MTHI/MTLO data
//  busy         out  1        operation in progress
//  done         out  1        one-cycle pulse; HI/LO hold the new result
//  div_by_zero  out  1        one-cycle pulse with done; DIV/DIVU had ALU_B==0
//  HI           out  DATA_W   product[63:32] / remainder
//  LO           out  DATA_W   product[31:0] / quotient
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy, done and div_by_zero = 0; HI=LO=0; counter=0.
//  FSM states: IDLE -> RUN -> FIX -> IDLE.
//  - IDLE: if start, latch |A| and |B| (signed ops) or A and B (unsigned ops).
//    Latch op and result signs, counter=0, go to RUN.
//  - RUN: one iteration per cycle for DATA_W cycles, then go to FIX.
//    Multiply: shift-add into a 2*DATA_W accumulator.
//    Divide: restoring shift-subtract.
//  - FIX: apply sign correction and write HI/LO, then go to IDLE.
//  Timing, with E0 the edge that samples start:
//  - busy=1 after E0 through E33.
//  - HI/LO are written at E33. done=1 for the single cycle after E33.
//  - Total latency is 34 cycles, start to done.
//  Signed multiply: 64-bit product is negated when A[31]^B[31].
//  Signed divide: quotient is negated when the signs differ; remainder takes the sign of the dividend.
//  Divide by zero: no iteration result is used.
//  - HI = dividend as given, LO = 32'hFFFF_FFFF.
//  - div_by_zero=1 with done. Latency is unchanged at 34.
//  Signed overflow (32'h8000_0000 / 32'hFFFF_FFFF): LO=32'h8000_0000, HI=0.
//  start while busy: ignored; the running op is not disturbed.
//  hi_we/lo_we while busy: ignored.
//  start together with hi_we/lo_we in IDLE: start wins; the write is dropped.
//  hi_we and lo_we together: both registers are written with wdata.
//  MTHI/MTLO writes land at the next edge; busy and done stay 0.
//  HI/LO are stable except at a FIX edge, a move write, or reset.
//  Reset mid-operation aborts the op; nothing partial reaches HI/LO.
//  All outputs are registered; there is no combinational input-to-output path.
// STRUCTURE
//  mdu_pkg:
//  - opcode localparams OP_MULT/OP_MULTU/OP_DIV/OP_DIVU.
//  - state encodings S_IDLE/S_RUN/S_FIX.
//  - DATA_W default.
//  One combinational sub-module, mdu_sign_adj: abs() on input and conditional 2's-complement negate on output.
//  It is instantiated for operand prep and for the FIX step.
//  The FSM, counter, accumulator and HI/LO registers stay in mult_div_unit.
// TESTING
//  1. MULT A=-3 (FFFFFFFD), B=7
//     -> done at cycle 34; HI=FFFFFFFF, LO=FFFFFFEB; busy high for 33 cycles.
//  2. MULTU A=FFFFFFFF, B=FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
//  3. DIV A=-7, B=2 -> LO=FFFFFFFD (-3), HI=FFFFFFFF (-1).
//     DIVU A=7, B=2 -> LO=3, HI=1.
//  4. DIVU A=1234, B=0 -> HI=1234, LO=FFFFFFFF, div_by_zero=1 with done.
//     DIV 80000000 / FFFFFFFF -> LO=80000000, HI=0.
//  5. Second start pulsed at cycle 10 of an op -> ignored; exactly one done; HI/LO from the first op.
//     lo_we=1, wdata=5 at cycle 10 -> ignored.
//  6. Reset asserted mid-RUN (cycle 20) -> busy=0, HI=LO=0 at once; no done.
//     Then MTHI 0xA5A5A5A5 -> HI=A5A5A5A5 next cycle, LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared constants for the iterative multiply/divide unit:
//               opcode encodings, FSM state encodings and default width.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Default operand width; HI and LO are each this wide
    localparam int MDU_DATA_W = 32;

    // Operation encodings on op[1:0]
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // FSM state encodings
    localparam int               STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] S_FIX  = 2'd2;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_sign_adj.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sign_adj
// Description : Conditional two's-complement negate. Driving negate with the
//               operand's own sign bit gives abs(); driving it with a result
//               sign gives the final sign correction.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_sign_adj #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Negate when requested, otherwise pass through unchanged
    always_comb begin
        result = value;
        if (negate) begin
            result = (~value) + ONE;
        end
    end

endmodule : mdu_sign_adj
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative multiply/divide unit for the EX stage. Runs
//               MULT/MULTU (shift-add) and DIV/DIVU (restoring divide) over
//               DATA_W iterations, then sign-corrects and writes HI/LO.
//               Also services MTHI/MTLO writes while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] ALU_A,
    input  logic [DATA_W-1:0] ALU_B,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [STATE_W-1:0]  state;
    logic [STATE_W-1:0]  state_next;
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] acc;        // product, or {remainder, quotient}
    logic [DATA_W-1:0]   operand_b;  // |multiplicand| or |divisor|
    logic [DATA_W-1:0]   dividend;   // raw A, returned in HI on divide by zero
    logic                is_div;
    logic                neg_q;      // product / quotient needs negating
    logic                neg_r;      // remainder needs negating
    logic                div0;

    // FSM control decodes
    logic load;
    logic step;
    logic finish;
    logic move_en;

    // ------------------------------------------------------------------
    // Operand preparation: magnitudes for signed ops
    // ------------------------------------------------------------------
    logic              op_signed;
    logic              op_is_div;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_is_div = (op == OP_DIV)  || (op == OP_DIVU);

    mdu_sign_adj #(.W(DATA_W)) u_abs_a (
        .value  (ALU_A),
        .negate (op_signed & ALU_A[DATA_W-1]),
        .result (mag_a)
    );

    mdu_sign_adj #(.W(DATA_W)) u_abs_b (
        .value  (ALU_B),
        .negate (op_signed & ALU_B[DATA_W-1]),
        .result (mag_b)
    );

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply / restoring divide
    // ------------------------------------------------------------------
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] acc_step;

    // Compute the accumulator value after one iteration
    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]}
                 + (acc[0] ? {1'b0, operand_b} : {(DATA_W+1){1'b0}});
        div_diff = acc[2*DATA_W-1:DATA_W-1] - {1'b0, operand_b};
        acc_step = acc;
        if (is_div) begin
            // A clear top bit means the trial subtraction did not borrow
            if (!div_diff[DATA_W]) begin
                acc_step = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            end else begin
                acc_step = {acc[2*DATA_W-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc[DATA_W-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Final sign correction
    // ------------------------------------------------------------------
    logic [2*DATA_W-1:0] prod_fixed;
    logic [DATA_W-1:0]   quo_fixed;
    logic [DATA_W-1:0]   rem_fixed;

    mdu_sign_adj #(.W(2*DATA_W)) u_fix_prod (
        .value  (acc),
        .negate (neg_q),
        .result (prod_fixed)
    );

    mdu_sign_adj #(.W(DATA_W)) u_fix_quo (
        .value  (acc[DATA_W-1:0]),
        .negate (neg_q),
        .result (quo_fixed)
    );

    mdu_sign_adj #(.W(DATA_W)) u_fix_rem (
        .value  (acc[2*DATA_W-1:DATA_W]),
        .negate (neg_r),
        .result (rem_fixed)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN for DATA_W cycles -> FIX -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (count == LAST_CNT) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Control decodes from the current state; start beats move writes
    always_comb begin
        busy    = (state != S_IDLE);
        load    = (state == S_IDLE) && start;
        step    = (state == S_RUN);
        finish  = (state == S_FIX);
        move_en = (state == S_IDLE) && !start;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // Latch operands on launch and iterate while running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            acc       <= '0;
            operand_b <= '0;
            dividend  <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div0      <= 1'b0;
        end else if (load) begin
            count     <= '0;
            acc       <= {{DATA_W{1'b0}}, mag_a};
            operand_b <= mag_b;
            dividend  <= ALU_A;
            is_div    <= op_is_div;
            neg_q     <= op_signed & (ALU_A[DATA_W-1] ^ ALU_B[DATA_W-1]);
            neg_r     <= op_signed & op_is_div & ALU_A[DATA_W-1];
            div0      <= op_is_div && (ALU_B == '0);
        end else if (step) begin
            count <= count + 1'b1;
            acc   <= acc_step;
        end
    end

    // HI/LO: written at the FIX edge or by MTHI/MTLO while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI <= '0;
            LO <= '0;
        end else if (finish) begin
            if (is_div && div0) begin
                HI <= dividend;
                LO <= ALL_ONES;
            end else if (is_div) begin
                HI <= rem_fixed;
                LO <= quo_fixed;
            end else begin
                HI <= prod_fixed[2*DATA_W-1:DATA_W];
                LO <= prod_fixed[DATA_W-1:0];
            end
        end else if (move_en) begin
            if (hi_we) HI <= wdata;
            if (lo_we) LO <= wdata;
        end
    end

    // Completion pulses, one cycle after the FIX edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= finish;
            div_by_zero <= finish & is_div & div0;
        end
    end

endmodule : mult_div_unit
`default_nettype wire
